// File: rtl/fir_pkg.sv
// Shared constants, state type and tap-count helper for the polyphase FIR engine.
package fir_pkg;

  localparam int NUM_TAPS = 71;
  localparam int L        = 4;
  localparam int TPP      = (NUM_TAPS + L - 1) / L;
  localparam int IN_W     = 8;
  localparam int COEF_W   = 8;
  localparam int ACC_W    = IN_W + COEF_W + 5;
  localparam int OUT_W    = 12;
  localparam int SHIFT    = 7;
  localparam int ADDR_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Number of taps that fall into a given phase: taps p, p+L, p+2L, ... below num_taps.
  function automatic int phase_taps(input int num_taps, input int l, input int phase);
    return (num_taps - phase + l - 1) / l;
  endfunction

endpackage

// File: rtl/polyphase_fir_engine_if.sv
// Symbol-in / sample-out handshake bundle of the polyphase FIR engine.
// master = upstream symbol source plus downstream sample sink; slave = engine.
interface polyphase_fir_engine_if;

  logic signed [fir_pkg::IN_W-1:0]  sym_in;
  logic                             sym_valid;
  logic                             sym_ready;
  logic signed [fir_pkg::OUT_W-1:0] y_out;
  logic                             y_valid;
  logic                             y_ready;

  modport master (
    output sym_in, sym_valid, y_ready,
    input  sym_ready, y_out, y_valid
  );

  modport slave (
    input  sym_in, sym_valid, y_ready,
    output sym_ready, y_out, y_valid
  );

endinterface

// File: rtl/sample_delay_line.sv
// Symbol delay line for the polyphase FIR: x[0] is the newest symbol.
// The read index is registered so the returned sample lines up with the
// coefficient that the array returns one cycle after its address.
module sample_delay_line
  import fir_pkg::*;
#(
  parameter int DEPTH = TPP,
  parameter int W     = IN_W,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic signed [W-1:0] din,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic signed [W-1:0] dout
);

  logic signed [W-1:0] x [DEPTH];
  logic [IDX_W-1:0]    idx_q;

  // Shift in a new symbol on accept; pipeline the read index every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is a shift register whose contents feed the
      // filter sums, so it must start from zero; a plain RAM would not be reset.
      for (int i = 0; i < DEPTH; i++) x[i] <= '0;
      idx_q <= '0;
    end else begin
      if (shift_en) begin
        x[0] <= din;
        for (int i = 1; i < DEPTH; i++) x[i] <= x[i-1];
      end
      idx_q <= rd_idx;
    end
  end

  assign dout = x[idx_q];

endmodule

// File: rtl/polyphase_fir_engine.sv
// Time-multiplexed single-multiplier L-phase interpolating FIR (one I/Q rail).
// Each accepted symbol produces L output samples; phase p sums h[p+L*k]*x[k].
// Build option FIR_ROUND_SAT_EN: round half up and saturate the output;
// without it the output is a truncating shift that wraps to OUT_W bits.
module polyphase_fir_engine
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = fir_pkg::NUM_TAPS,
  parameter int L        = fir_pkg::L,
  parameter int IN_W     = fir_pkg::IN_W,
  parameter int COEF_W   = fir_pkg::COEF_W,
  parameter int ACC_W    = fir_pkg::ACC_W,
  parameter int OUT_W    = fir_pkg::OUT_W,
  parameter int SHIFT    = fir_pkg::SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  polyphase_fir_engine_if.slave    io,
  output logic [ADDR_W-1:0]        coeff_addr,
  input  logic signed [COEF_W-1:0] coeff_data,
  output logic                     busy
);

  localparam int TAPS_PP = (NUM_TAPS + L - 1) / L;
  localparam int PH_W    = $clog2(L);
  localparam int K_W     = $clog2(TAPS_PP);
  localparam int PROD_W  = IN_W + COEF_W;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(L);
  localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'(L - 1);

  state_t                   state, state_next;
  logic [PH_W-1:0]          phase;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc, acc_sum;
  logic signed [PROD_W-1:0] prod;
  logic signed [IN_W-1:0]   sample;
  logic signed [OUT_W-1:0]  y_next, y_reg;
  logic                     sym_fire, last_issue, acc_en;

  assign sym_fire   = io.sym_valid && io.sym_ready;
  assign last_issue = (int'(k) == phase_taps(NUM_TAPS, L, int'(phase)) - 1);
  // Cycle 0 of MAC has no returned coefficient yet; DRAIN picks up the last one.
  assign acc_en     = ((state == MAC) && (k != '0)) || (state == DRAIN);

  sample_delay_line #(
    .DEPTH (TAPS_PP),
    .W     (IN_W),
    .IDX_W (K_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (sym_fire),
    .din      (io.sym_in),
    .rd_idx   (k),
    .dout     (sample)
  );

  assign prod    = coeff_data * sample;
  assign acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2**(SHIFT-1));
  localparam int SAT_HI = 2**(OUT_W-1+SHIFT);
  localparam int SAT_LO = -(2**(OUT_W-1+SHIFT));
  logic signed [ACC_W:0] rounded;

  // Round half up, then clamp to the signed OUT_W range before the shift.
  always_comb begin
    rounded = {acc_sum[ACC_W-1], acc_sum} + RND;
    y_next  = rounded[SHIFT +: OUT_W];
    if (int'(rounded) >= SAT_HI)     y_next = {1'b0, {(OUT_W-1){1'b1}}};
    else if (int'(rounded) < SAT_LO) y_next = {1'b1, {(OUT_W-1){1'b0}}};
  end
`else
  // Truncating arithmetic shift; keeping only OUT_W bits lets large sums wrap.
  always_comb begin
    y_next = acc_sum[SHIFT +: OUT_W];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      IDLE:    if (sym_fire)   state_next = MAC;
      MAC:     if (last_issue) state_next = DRAIN;
      DRAIN:                   state_next = EMIT;
      EMIT:    if (io.y_ready) state_next = (phase == LAST_PHASE) ? IDLE : MAC;
      default:                 state_next = IDLE;
    endcase
  end

  // Moore outputs; sym_ready is forced low while reset is asserted.
  always_comb begin
    io.sym_ready = rst_n && (state == IDLE);
    io.y_valid   = (state == EMIT);
    busy         = (state != IDLE);
    io.y_out     = y_reg;
  end

  // Datapath: phase/tap counters, coefficient address, accumulator, output sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      k          <= '0;
      coeff_addr <= '0;
      acc        <= '0;
      y_reg      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sym_fire) begin
            phase      <= '0;
            k          <= '0;
            coeff_addr <= '0;
            acc        <= '0;
          end
        end
        MAC: begin
          if (acc_en) acc <= acc_sum;
          if (!last_issue) begin
            k          <= k + 1'b1;
            coeff_addr <= coeff_addr + ADDR_STEP;
          end
        end
        DRAIN: begin
          acc   <= acc_sum;
          y_reg <= y_next;
        end
        EMIT: begin
          if (io.y_ready && (phase != LAST_PHASE)) begin
            phase      <= phase + 1'b1;
            k          <= '0;
            coeff_addr <= ADDR_W'(phase) + ADDR_W'(1);
            acc        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polyphase_fir_engine.sv
// Directed testbench for polyphase_fir_engine: impulse, latency, backpressure,
// busy-ignore, mid-operation reset and saturation/wrap vectors.
// Expected values follow FIR_ROUND_SAT_EN when the bench is built with it.
module tb_polyphase_fir_engine;
  import fir_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [ADDR_W-1:0]        coeff_addr;
  logic signed [COEF_W-1:0] coeff_data;
  logic                     busy;

  polyphase_fir_engine_if io ();

  polyphase_fir_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Coefficient array model with one-cycle read latency.
  logic signed [COEF_W-1:0] h [NUM_TAPS];
  always @(posedge clk)
    coeff_data <= (int'(coeff_addr) < NUM_TAPS) ? h[coeff_addr] : '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ys [4];
  int lat_valid, lat_ready;
  int hold_bad_y, hold_bad_addr, hold_bad_ready, hold_bad_valid;
  int e_imp0 [4];
  int e_imp1 [4];
  int e_sat  [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ys(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_p0"}, ys[0], e0);
    check({tag, "_p1"}, ys[1], e1);
    check({tag, "_p2"}, ys[2], e2);
    check({tag, "_p3"}, ys[3], e3);
  endtask

  // Feed one symbol and collect its four outputs; called and returns at a negedge.
  // hold_phase: output index during which y_ready is held low for 10 cycles.
  // noise: toggle sym_valid / sym_in while the engine is busy.
  // abort_phase: assert reset partway into that phase's MAC and return.
  task automatic run_symbol(input int v, input int hold_phase, input bit noise, input int abort_phase);
    int n, idx, wait_n;
    logic signed [OUT_W-1:0] saved_y;
    logic [ADDR_W-1:0]       saved_addr;
    idx = 0; lat_valid = -1; lat_ready = -1; wait_n = 0;
    hold_bad_y = 0; hold_bad_addr = 0; hold_bad_ready = 0; hold_bad_valid = 0;
    for (int i = 0; i < 4; i++) ys[i] = -9999;
    while (!io.sym_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check("sym_ready_before_send", int'(io.sym_ready), 1);
    if (!io.sym_ready) return;
    io.sym_in    = 8'(v);
    io.sym_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.sym_valid = 1'b0;
    io.sym_in    = '0;
    n = 1;
    while (n < 400) begin
      if (abort_phase >= 0 && idx == abort_phase && n >= 20 * abort_phase + 6) begin
        rst_n = 1'b0;
        return;
      end
      if (io.y_valid) begin
        io.sym_valid = 1'b0;
        if (lat_valid < 0) lat_valid = n;
        if (idx == hold_phase) begin
          saved_y    = io.y_out;
          saved_addr = coeff_addr;
          io.y_ready = 1'b0;
          repeat (10) begin
            @(negedge clk);
            n++;
            if (io.y_out !== saved_y)      hold_bad_y++;
            if (coeff_addr !== saved_addr) hold_bad_addr++;
            if (io.sym_ready !== 1'b0)     hold_bad_ready++;
            if (io.y_valid !== 1'b1)       hold_bad_valid++;
          end
          io.y_ready = 1'b1;
        end
        ys[idx] = int'(io.y_out);
        idx++;
      end else if (idx == 4 && io.sym_ready) begin
        lat_ready = n;
        break;
      end else if (noise && idx < 4 && busy) begin
        io.sym_valid = n[0];
        io.sym_in    = 8'(n * 37 + 5);
      end
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FIR_ROUND_SAT_EN
    e_imp0 = '{5, 6, 6, 7};
    e_imp1 = '{7, 8, 8, 9};
    e_sat  = '{2047, 2047, 2047, 2047};
`else
    e_imp0 = '{5, 5, 6, 6};
    e_imp1 = '{7, 7, 8, 8};
    e_sat  = '{-1828, -1828, -1828, -1954};
`endif
    for (int i = 0; i < NUM_TAPS; i++) h[i] = 8'(i + 10);
    io.sym_in    = '0;
    io.sym_valid = 1'b0;
    io.y_ready   = 1'b1;
    rst_n        = 1'b0;

    // Reset values while rst_n is low.
    repeat (3) @(negedge clk);
    check("rst_sym_ready", int'(io.sym_ready), 0);
    check("rst_y_valid",   int'(io.y_valid), 0);
    check("rst_y_out",     int'(io.y_out), 0);
    check("rst_coeff_addr", int'(coeff_addr), 0);
    check("rst_busy",      int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sym_ready", int'(io.sym_ready), 1);
    check("post_rst_busy",      int'(busy), 0);

    // Impulse of 64 into an empty delay line: h[p]*64 >>> 7, plus latency.
    run_symbol(64, -1, 1'b0, -1);
    check("imp0_lat_valid", lat_valid, 20);
    check("imp0_lat_ready", lat_ready, 80);
    check_ys("imp0", e_imp0[0], e_imp0[1], e_imp0[2], e_imp0[3]);

    // Zero symbol shifts the impulse to x[1]; y_ready held low during phase 1 EMIT.
    run_symbol(0, 1, 1'b0, -1);
    check("imp1_lat_valid", lat_valid, 20);
    check_ys("imp1_hold", e_imp1[0], e_imp1[1], e_imp1[2], e_imp1[3]);
    check("hold_y_out_changes",   hold_bad_y, 0);
    check("hold_addr_changes",    hold_bad_addr, 0);
    check("hold_sym_ready_high",  hold_bad_ready, 0);
    check("hold_y_valid_dropped", hold_bad_valid, 0);

    // Impulse now at x[2]: phase 0 = h[8]*64 = 1152 -> 9; reset during phase 2 MAC.
    run_symbol(0, -1, 1'b0, 2);
    check("imp2_p0_before_abort", ys[0], 9);
    #1;
    check("abort_sym_ready",  int'(io.sym_ready), 0);
    check("abort_y_valid",    int'(io.y_valid), 0);
    check("abort_y_out",      int'(io.y_out), 0);
    check("abort_coeff_addr", int'(coeff_addr), 0);
    check("abort_busy",       int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Delay line was cleared: the first-impulse outputs must repeat.
    run_symbol(64, -1, 1'b0, -1);
    check("reimp0_lat_valid", lat_valid, 20);
    check("reimp0_lat_ready", lat_ready, 80);
    check_ys("reimp0", e_imp0[0], e_imp0[1], e_imp0[2], e_imp0[3]);

    // sym_valid toggling with junk data while busy must not disturb anything.
    run_symbol(0, -1, 1'b1, -1);
    check_ys("noise_imp1", e_imp1[0], e_imp1[1], e_imp1[2], e_imp1[3]);

    // Saturation / wrap: all taps 127, 18 symbols of 127 fill the delay line.
    for (int i = 0; i < NUM_TAPS; i++) h[i] = 8'sd127;
    for (int s = 0; s < 18; s++) run_symbol(127, -1, 1'b0, -1);
    check_ys("sat18", e_sat[0], e_sat[1], e_sat[2], e_sat[3]);
    check("sat18_lat_ready", lat_ready, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/polyphase_fir_engine.md
# polyphase_fir_engine

Time-multiplexed, single-multiplier 4-phase interpolating FIR for one rail (I or Q) of the 64QAM modulator. It accepts one 8-bit signed symbol level per handshake and produces four filtered output samples per symbol. It sits directly downstream of the coefficient register array: it drives that array's read address and consumes its 8-bit coefficient output. The host writes coefficients only while the engine is idle.

## Interface
Parameters:
- NUM_TAPS, 71: total filter taps; must match the coefficient array depth in use.
- L, 4: interpolation factor (number of phases).
- IN_W, 8: signed symbol width.
- COEF_W, 8: signed coefficient width, Q1.7.
- ACC_W, 21: accumulator width (IN_W + COEF_W + 5).
- OUT_W, 12: signed output width.
- SHIFT, 7: right shift applied to the accumulator before output.

Ports:
- clk  in  1  rising-edge clock, 108.333 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sym_in  in  IN_W  signed symbol level.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  engine accepts a symbol this cycle.
- coeff_addr  out  7  tap index sent to the coefficient array (registered).
- coeff_data  in  COEF_W  coefficient for the address presented in the previous cycle (1-cycle read latency).
- y_out  out  OUT_W  filtered sample.
- y_valid  out  1  y_out is valid.
- y_ready  in  1  downstream accepts y_out.
- busy  out  1  high in any state other than IDLE.

## Operation
- Delay line: TPP = ceil(NUM_TAPS/L) = 18 signed IN_W entries, x[0] is the newest. It shifts only on a sym_valid && sym_ready handshake.
- Phase p output: y_p = sum over k of h[p+L*k] * x[k], for all k with p+L*k ≤ NUM_TAPS-1.
  - Phases 0–2 use 18 taps.
  - Phase 3 uses 17 taps.
- States and transitions:
  - IDLE: sym_ready=1. On handshake, shift the delay line, set phase=0, clear the accumulator, go to MAC.
  - MAC: issue coeff_addr = p + L*k for k = 0..ntap_p−1, one per cycle. Each cycle, accumulate the coefficient returned for the previous address times its aligned sample. After the last issue, go to DRAIN.
  - DRAIN: one cycle; final accumulate. Go to EMIT.
  - EMIT: y_valid=1, y_out held stable. On y_ready: if phase < 3, increment phase, clear the accumulator, go to MAC; otherwise go to IDLE.
- Arithmetic:
  - Product: signed IN_W × COEF_W, 16 bits, sign-extended to ACC_W.
  - Accumulator overflow is impossible with the default widths.
  - Output = acc >>> SHIFT, reduced to OUT_W bits as set by the Configuration macro.
- Boundaries:
  - The delay line starts at all zeros after reset, so the first symbols yield partial sums.
  - sym_valid while busy: ignored; sym_ready stays low and sym_in is not sampled.
  - y_ready low in EMIT: hold indefinitely; no address activity.
  - Reset mid-operation: immediate return to IDLE; delay line, accumulator and phase cleared.

## Timing
- Reset values:
  - sym_ready=1 once reset is released; 0 while rst_n is low.
  - y_valid=0, y_out=0, coeff_addr=0, busy=0.
- With y_ready held high, y_valid first asserts 20 cycles after the accepting edge (18 issue + 1 drain + 1 register).
- Later phases each take ntap_p + 2 cycles: 20, 20, 19.
- Minimum symbol period: 1 + 20×3 + 19 = 80 cycles; sym_ready is high only in IDLE.
- coeff_addr changes only in MAC; it holds its last value otherwise.

## Configuration
- FIR_ROUND_SAT_EN defined:
  - Add 2^(SHIFT−1) before the shift (round half up).
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- FIR_ROUND_SAT_EN undefined: plain arithmetic shift (truncation); keep the low OUT_W bits, so out-of-range values wrap.

## Structure
- Package fir_pkg holds:
  - Constants: NUM_TAPS, L, TPP, widths, SHIFT.
  - Per-phase tap-count function.
  - State enum type: IDLE, MAC, DRAIN, EMIT.
- One sub-module, sample_delay_line:
  - TPP-deep shift register with async clear.
  - Indexed read port; index pipelined one cycle to align with coeff_data.

## Test plan
- Coefficient model: behavioural array with 1-cycle read latency; h[i] = i + 10 unless stated otherwise. Hold y_ready high unless stated otherwise.
- Impulse: sym_in = 64, then zeros.
  - Symbol 0 outputs: 5, 5, 6, 6 without the macro; 5, 6, 6, 7 with it.
  - Next symbol's outputs: 7, 7, 8, 8 without the macro; 7, 8, 8, 9 with it.
- Saturation: all h = 127, sym_in = 127 for 18 symbols.
  - 18th symbol with the macro: 2047 on all four phases.
  - Without the macro: −1828, −1828, −1828, −1954.
- Latency: y_valid rises exactly 20 cycles after the first accept; the next sym_ready rises 80 cycles after that accept.
- Backpressure: hold y_ready low for 10 cycles in phase 1 EMIT.
  - y_out stable, coeff_addr static, sym_ready=0.
  - The sequence resumes unchanged when y_ready is released.
- Busy ignore: toggle sym_valid with varied sym_in during MAC → delay line unchanged; the output sequence is identical to the clean impulse run.
- Reset mid-MAC: pull rst_n low during phase 2.
  - All outputs return to reset values.
  - After release, an impulse of 64 reproduces the first-impulse outputs, proving the delay line was cleared.
